// File: rtl/aes_pkg.sv
// aes_pkg: shared AES inverse-cipher types, byte layout, InvSBox and GF(2^8) helpers.
package aes_pkg;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

   localparam int AES128_NR = 10;
   localparam int AES192_NR = 12;
   localparam int AES256_NR = 14;

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic int bidx(int col, int row);
      return 4 * col + row;
   endfunction

   function automatic logic [7:0] inv_sbox(logic [7:0] b);
      return INV_SBOX[b];
   endfunction

   function automatic logic [7:0] xtime(logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul_9(logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] mul_b(logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] mul_d(logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] mul_e(logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: combinational inverse round; InvMixColumns bypassed on the last round.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] round_key_i,
   input  logic         last_i,
   output logic [127:0] next_o
);
   logic [127:0] sr, sb, ak, mc;
   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [31:0] col;
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[8*bidx(c, r) +: 8] = state_i[8*bidx((c - r + 4) % 4, r) +: 8];
         assign sb[8*bidx(c, r) +: 8] = inv_sbox(sr[8*bidx(c, r) +: 8]);
      end
      assign col = ak[32*c +: 32];
      assign mc[32*c +: 32] = {
         mul_b(col[7:0]) ^ mul_d(col[15:8]) ^ mul_9(col[23:16]) ^ mul_e(col[31:24]),
         mul_d(col[7:0]) ^ mul_9(col[15:8]) ^ mul_e(col[23:16]) ^ mul_b(col[31:24]),
         mul_9(col[7:0]) ^ mul_e(col[15:8]) ^ mul_b(col[23:16]) ^ mul_d(col[31:24]),
         mul_e(col[7:0]) ^ mul_b(col[15:8]) ^ mul_d(col[23:16]) ^ mul_9(col[31:24])
      };
   end
   assign ak = sb ^ round_key_i;
   assign next_o = last_i ? ak : mc;
endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: iterative AES inverse cipher, one round per clock through a shared datapath.
module aes_inv_cipher_ctrl
   import aes_pkg::*;
#(
   parameter int NR = AES128_NR
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic [3:0]   key_idx,
   input  logic [127:0] round_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);
   state_e       state_q;
   logic [3:0]   r_q;
   logic [127:0] data_q, round_out;

   aes_inv_round u_round (
      .state_i    (data_q),
      .round_key_i(round_key),
      .last_i     (r_q == 4'd0),
      .next_o     (round_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               data_q  <= in_data ^ round_key;
               r_q     <= 4'(NR - 1);
               state_q <= ROUND;
            end
            ROUND: begin
               data_q  <= round_out;
               r_q     <= (r_q == 4'd0) ? r_q : r_q - 4'd1;
               state_q <= (r_q == 4'd0) ? DONE : ROUND;
            end
            DONE: if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign busy      = state_q != IDLE;
   assign key_idx   = (state_q == IDLE) ? 4'(NR) : (state_q == ROUND) ? r_q : 4'd0;
   assign out_data  = data_q;
endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// tb_aes_inv_cipher_ctrl: directed + random blocks against a FIPS-197 reference decryptor.
module tb_aes_inv_cipher_ctrl;
   localparam int NR = 10;

   logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [127:0] in_data = '0, out_data, round_key;
   logic         in_ready, out_valid, busy;
   logic [3:0]   key_idx;
   logic [127:0] rk [16];
   logic [7:0]   sbox [256], isbox [256];
   logic [127:0] c1_key, c1_ct, c1_pt, z_ct, ct, key;
   int           n_checks = 0, n_err = 0;

   always #5 clk = ~clk;
   assign round_key = rk[key_idx];

   aes_inv_cipher_ctrl #(.NR(NR)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .key_idx(key_idx), .round_key(round_key), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy)
   );

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(logic [7:0] b, int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [127:0] bswap(logic [127:0] v);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = v[8*(15-i) +: 8];
      return o;
   endfunction

   // S-box built from the GF(2^8) inverse plus affine map, independent of any table.
   task automatic init_sbox();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         sbox[x] = s;
         isbox[s] = 8'(x);
      end
   endtask

   task automatic load_key(logic [127:0] k);
      logic [7:0] ek [176];
      logic [7:0] t [4];
      logic [7:0] rc = 8'h01, t0;
      for (int i = 0; i < 16; i++) ek[i] = k[8*i +: 8];
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) t[j] = ek[i-4+j];
         if (i % 16 == 0) begin
            t0 = t[0];
            t[0] = sbox[t[1]] ^ rc;
            t[1] = sbox[t[2]];
            t[2] = sbox[t[3]];
            t[3] = sbox[t0];
            rc = gmul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) ek[i+j] = ek[i-16+j] ^ t[j];
      end
      for (int n = 0; n < 16; n++)
         for (int i = 0; i < 16; i++) rk[n][8*i +: 8] = (n <= NR) ? ek[16*n+i] : 8'h00;
   endtask

   function automatic logic [127:0] ref_decrypt(logic [127:0] c);
      logic [7:0] s [16], t [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) s[i] = c[8*i +: 8] ^ rk[NR][8*i +: 8];
      for (int n = NR - 1; n >= 0; n--) begin
         for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++)
               t[4*col+row] = isbox[s[4*((col-row+4)%4)+row]] ^ rk[n][8*(4*col+row) +: 8];
         for (int col = 0; col < 4; col++) begin
            if (n > 0) begin
               s[4*col]   = gmul(t[4*col],8'h0e)^gmul(t[4*col+1],8'h0b)^gmul(t[4*col+2],8'h0d)^gmul(t[4*col+3],8'h09);
               s[4*col+1] = gmul(t[4*col],8'h09)^gmul(t[4*col+1],8'h0e)^gmul(t[4*col+2],8'h0b)^gmul(t[4*col+3],8'h0d);
               s[4*col+2] = gmul(t[4*col],8'h0d)^gmul(t[4*col+1],8'h09)^gmul(t[4*col+2],8'h0e)^gmul(t[4*col+3],8'h0b);
               s[4*col+3] = gmul(t[4*col],8'h0b)^gmul(t[4*col+1],8'h0d)^gmul(t[4*col+2],8'h09)^gmul(t[4*col+3],8'h0e);
            end else begin
               for (int row = 0; row < 4; row++) s[4*col+row] = t[4*col+row];
            end
         end
      end
      for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
      return o;
   endfunction

   task automatic chk_ctl(string tag, logic er, logic ev, logic eb, logic [3:0] ek);
      n_checks++;
      assert ({in_ready, out_valid, busy, key_idx} === {er, ev, eb, ek}) else begin
         n_err++;
         $error("FAIL %s: rdy/vld/busy/idx got %b%b%b/%0d expected %b%b%b/%0d",
                tag, in_ready, out_valid, busy, key_idx, er, ev, eb, ek);
      end
   endtask

   task automatic chk_data(string tag, logic [127:0] exp);
      n_checks++;
      assert (out_data === exp) else begin
         n_err++;
         $error("FAIL %s: out_data got %h expected %h", tag, out_data, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(logic [127:0] c);
      in_valid = 1'b1;
      in_data  = c;
      chk_ctl("idle", 1'b1, 1'b0, 1'b0, 4'(NR));
      step();
      in_valid = 1'b0;
   endtask

   task automatic run_rounds(string tag, logic [127:0] exp);
      for (int k = NR - 1; k >= 0; k--) begin
         chk_ctl(tag, 1'b0, 1'b0, 1'b1, 4'(k));
         step();
      end
      chk_ctl(tag, 1'b0, 1'b1, 1'b1, 4'd0);
      chk_data(tag, exp);
   endtask

   task automatic finish_out();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk_ctl("release", 1'b1, 1'b0, 1'b0, 4'(NR));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] hold;
      init_sbox();
      c1_key = bswap(128'h000102030405060708090a0b0c0d0e0f);
      c1_ct  = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      c1_pt  = bswap(128'h00112233445566778899aabbccddeeff);
      z_ct   = bswap(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      load_key(c1_key);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_ctl("reset", 1'b1, 1'b0, 1'b0, 4'd10);
      chk_data("reset", '0);

      accept(c1_ct);
      run_rounds("c1", c1_pt);
      finish_out();

      load_key('0);
      accept(z_ct);
      run_rounds("zero", '0);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         step();
         chk_ctl("backpressure", 1'b0, 1'b1, 1'b1, 4'd0);
         chk_data("backpressure", '0);
      end
      in_valid = 1'b0;
      finish_out();
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
      load_key(key);
      hold = ref_decrypt(ct);
      accept(ct);
      run_rounds("after_bp", hold);
      finish_out();

      for (int b = 0; b < 5; b++) begin
         key = {$urandom(), $urandom(), $urandom(), $urandom()};
         ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
         load_key(key);
         hold = ref_decrypt(ct);
         accept(ct);
         run_rounds("random", hold);
         repeat ($urandom_range(0, 3)) begin
            step();
            chk_ctl("random_hold", 1'b0, 1'b1, 1'b1, 4'd0);
            chk_data("random_hold", hold);
         end
         finish_out();
      end

      load_key(c1_key);
      in_valid  = 1'b1;
      in_data   = c1_ct;
      out_ready = 1'b1;
      chk_ctl("b2b_idle", 1'b1, 1'b0, 1'b0, 4'(NR));
      step();
      in_data = z_ct;
      run_rounds("b2b_first", c1_pt);
      load_key('0);
      step();
      chk_ctl("b2b_gap", 1'b1, 1'b0, 1'b0, 4'(NR));
      step();
      in_valid = 1'b0;
      run_rounds("b2b_second", '0);
      step();
      out_ready = 1'b0;
      chk_ctl("b2b_release", 1'b1, 1'b0, 1'b0, 4'(NR));

      load_key(c1_key);
      accept(c1_ct);
      repeat (4) step();
      chk_ctl("pre_abort", 1'b0, 1'b0, 1'b1, 4'd5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_ctl("abort", 1'b1, 1'b0, 1'b0, 4'(NR));
      chk_data("abort", '0);
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk_ctl("no_out_after_abort", 1'b1, 1'b0, 1'b0, 4'(NR));
      end
      out_ready = 1'b0;
      accept(c1_ct);
      run_rounds("c1_again", c1_pt);
      finish_out();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
